reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 110 +++++++++++
 tb/tb_reg_file_sb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with per-register busy scoreboard and write forwarding
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                WR_EN,
    input  logic                SET,
    input  logic                RESET,
    input  logic [AW-1:0]       write_select,
    input  logic [XLEN-1:0]     data_in,
    input  logic [NRD*AW-1:0]   rd_select,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                alloc_valid,
    input  logic [AW-1:0]       alloc_sel,
    output logic                alloc_ready,
    output logic [AW:0]         busy_count
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             commit;
    logic [XLEN-1:0]  commit_val;
    logic             alloc_acc;
    logic             count_inc;
    logic             count_dec;

    // A commit is any write/clear/set aimed at a real register; reset squashes it
    // so forwarded read data is also zero while reset is held.
    assign commit = (WR_EN || RESET || SET) && (write_select != '0) && !reset;

    // Value being committed: WR_EN beats RESET beats SET.
    always_comb begin
        commit_val = '0;
        if (WR_EN) begin
            commit_val = data_in;
        end else if (RESET) begin
            commit_val = '0;
        end else begin
            commit_val = XLEN'(1);
        end
    end

    // A busy register may be re-reserved only when its producer commits this cycle.
    assign alloc_ready = (alloc_sel == '0) || !busy[alloc_sel]
                       || (commit && (write_select == alloc_sel));
    assign alloc_acc   = alloc_valid && alloc_ready && (alloc_sel != '0);

    // Next busy vector: commit clears first, a same-register allocation then re-sets.
    always_comb begin
        busy_next = busy;
        if (commit) begin
            busy_next[write_select] = 1'b0;
        end
        if (alloc_acc) begin
            busy_next[alloc_sel] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Count moves only on real 0->1 and 1->0 busy transitions.
    always_comb begin
        count_inc = alloc_acc && !busy[alloc_sel];
        count_dec = commit && busy[write_select]
                  && !(alloc_acc && (alloc_sel == write_select));
    end

    // Register storage; entry 0 is only ever loaded with zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[write_select] <= commit_val;
        end
    end

    // Scoreboard state: busy bits and their population count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count + {{AW{1'b0}}, count_inc} - {{AW{1'b0}}, count_dec};
        end
    end

    // Combinational read ports with optional forwarding of the in-flight commit.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] sel;
        logic          hit;
        logic          same_alloc;

        assign sel        = rd_select[i*AW +: AW];
        assign hit        = (BYPASS != 0) && commit && (write_select == sel);
        assign same_alloc = alloc_acc && (alloc_sel == sel);

        assign rd_data[i*XLEN +: XLEN] = hit ? commit_val : regs[sel];
        assign rd_busy[i]              = busy[sel] && !(hit && !same_alloc);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized and directed check of reg_file_sb against a reference model
module tb_reg_file_sb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we, st, rs, av;
    logic [4:0]  ws, as, r0, r1;
    logic [31:0] din;
    logic [9:0]  rd_sel;
    logic [63:0] b_rd, n_rd;
    logic [1:0]  b_busy, n_busy;
    logic        b_ready, n_ready;
    logic [5:0]  b_cnt, n_cnt;

    logic [31:0] mreg  [32];
    bit          mbusy [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    assign rd_sel = {r1, r0};

    always #5 clock = ~clock;

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_byp (
        .clock(clock), .reset(reset), .WR_EN(we), .SET(st), .RESET(rs),
        .write_select(ws), .data_in(din), .rd_select(rd_sel), .rd_data(b_rd),
        .rd_busy(b_busy), .alloc_valid(av), .alloc_sel(as),
        .alloc_ready(b_ready), .busy_count(b_cnt)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_nob (
        .clock(clock), .reset(reset), .WR_EN(we), .SET(st), .RESET(rs),
        .write_select(ws), .data_in(din), .rd_select(rd_sel), .rd_data(n_rd),
        .rd_busy(n_busy), .alloc_valid(av), .alloc_sel(as),
        .alloc_ready(n_ready), .busy_count(n_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit m_commit();
        return (we || rs || st) && (ws != 0);
    endfunction

    function automatic logic [31:0] m_val();
        if (we) return din;
        if (rs) return 32'd0;
        return 32'd1;
    endfunction

    function automatic bit m_ready();
        return (as == 0) || !mbusy[as] || (m_commit() && ws == as);
    endfunction

    function automatic bit m_acc();
        return av && m_ready() && (as != 0);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'd0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic w, input logic s, input logic r, input logic [4:0] wsel,
                         input logic [31:0] d, input logic a, input logic [4:0] asel,
                         input logic [4:0] s0, input logic [4:0] s1);
        we = w; st = s; rs = r; ws = wsel; din = d; av = a; as = asel; r0 = s0; r1 = s1;
    endtask

    task automatic idle(input logic [4:0] s0, input logic [4:0] s1);
        drive(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, s0, s1);
    endtask

    task automatic compare_outputs();
        for (int p = 0; p < 2; p++) begin
            logic [4:0] sel;
            bit         hit;
            sel = (p == 1) ? r1 : r0;
            hit = m_commit() && (ws == sel);
            check("rd_data_byp", b_rd[p*32 +: 32], hit ? m_val() : mreg[sel]);
            check("rd_data_nob", n_rd[p*32 +: 32], mreg[sel]);
            check("rd_busy_byp", b_busy[p], mbusy[sel] && !(hit && !(m_acc() && as == sel)));
            check("rd_busy_nob", n_busy[p], mbusy[sel]);
        end
        check("alloc_ready_byp", b_ready, m_ready());
        check("alloc_ready_nob", n_ready, m_ready());
        check("busy_count_byp", b_cnt, m_count());
        check("busy_count_nob", n_cnt, m_count());
    endtask

    // Inputs are applied just after a rising edge; this checks mid-cycle and applies the edge to the model.
    task automatic do_cycle();
        bit          c, a;
        logic [31:0] v;
        @(negedge clock);
        compare_outputs();
        @(posedge clock);
        c = m_commit();
        v = m_val();
        a = m_acc();
        if (c) begin
            mreg[ws]  = v;
            mbusy[ws] = 1'b0;
        end
        if (a) mbusy[as] = 1'b1;
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_count_byp", b_cnt, 0);
        check("rst_count_nob", n_cnt, 0);
        check("rst_rd_byp", b_rd, 64'd0);
        check("rst_rd_nob", n_rd, 64'd0);
        check("rst_busy_byp", b_busy, 0);
        check("rst_ready_byp", b_ready, 1);
    endtask

    task automatic reset_dut(input int hold_edges);
        reset = 1'b1;
        #1;
        m_clear();
        check_reset_outputs();
        for (int e = 0; e < hold_edges; e++) begin
            @(posedge clock);
            #1;
            check_reset_outputs();
        end
        idle(5'd0, 5'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] rnd_idx();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 9));
    endfunction

    initial begin
        m_clear();
        idle(5'd5, 5'd0);
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // First edge after release commits; forwarding vs old value.
        drive(1, 0, 0, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0);
        #1;
        check("fwd_byp_x5", b_rd[31:0], 32'hDEADBEEF);
        check("nofwd_nob_x5", n_rd[31:0], 32'd0);
        do_cycle();
        idle(5'd5, 5'd0);
        #1;
        check("held_x5", b_rd[31:0], 32'hDEADBEEF);
        check("held_x5_nob", n_rd[31:0], 32'hDEADBEEF);
        do_cycle();
        drive(1, 0, 0, 5'd0, 32'h1234, 0, 5'd0, 5'd0, 5'd5);
        #1;
        check("x0_write_fwd", b_rd[31:0], 32'd0);
        do_cycle();
        idle(5'd0, 5'd5);
        #1;
        check("x0_after_write", b_rd[31:0], 32'd0);
        do_cycle();

        // Write priority.
        drive(1, 1, 1, 5'd7, 32'hA5, 0, 5'd0, 5'd7, 5'd0);
        do_cycle();
        drive(0, 1, 1, 5'd7, 32'hFF, 0, 5'd0, 5'd7, 5'd0);
        #1;
        check("prio_all_nob", n_rd[31:0], 32'hA5);
        check("prio_reset_byp", b_rd[31:0], 32'd0);
        do_cycle();
        drive(0, 1, 0, 5'd7, 32'hFF, 0, 5'd0, 5'd7, 5'd0);
        #1;
        check("prio_set_byp", b_rd[31:0], 32'd1);
        check("prio_set_nob", n_rd[31:0], 32'd0);
        do_cycle();
        idle(5'd7, 5'd0);
        #1;
        check("set_x7", b_rd[31:0], 32'd1);
        do_cycle();

        // Allocation, refused re-allocation, commit clears.
        drive(0, 0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 5'd3);
        do_cycle();
        drive(0, 0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 5'd3);
        #1;
        check("realloc_ready", b_ready, 0);
        check("alloc_count", b_cnt, 1);
        check("alloc_rd_busy", b_busy[1], 1);
        do_cycle();
        drive(1, 0, 0, 5'd3, 32'h55, 0, 5'd0, 5'd0, 5'd3);
        #1;
        check("commit_busy_byp", b_busy[1], 0);
        check("commit_busy_nob", n_busy[1], 1);
        do_cycle();
        idle(5'd3, 5'd0);
        #1;
        check("commit_count", b_cnt, 0);
        check("commit_x3", b_rd[31:0], 32'h55);
        do_cycle();

        // Same-edge commit and re-allocation.
        drive(0, 0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd0, 5'd0);
        do_cycle();
        drive(1, 0, 0, 5'd9, 32'h77, 1, 5'd9, 5'd9, 5'd0);
        #1;
        check("same_edge_ready", b_ready, 1);
        do_cycle();
        idle(5'd9, 5'd0);
        #1;
        check("same_edge_x9", b_rd[31:0], 32'h77);
        check("same_edge_busy", b_busy[0], 1);
        check("same_edge_count", b_cnt, 1);
        do_cycle();
        reset_dut(0);

        // Fill the scoreboard, then net set/clear, then reset mid-operation.
        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 5'd0, 32'd0, 1, 5'(i), 5'(i), 5'd0);
            do_cycle();
        end
        idle(5'd1, 5'd4);
        #1;
        check("full_count", b_cnt, 31);
        drive(1, 0, 0, 5'd4, 32'h44, 1, 5'd0, 5'd4, 5'd0);
        do_cycle();
        idle(5'd4, 5'd0);
        #1;
        check("net_count", b_cnt, 30);
        drive(1, 0, 0, 5'd6, 32'hCAFE, 1, 5'd5, 5'd4, 5'd1);
        reset_dut(1);
        idle(5'd6, 5'd4);
        #1;
        check("discard_x6", b_rd[31:0], 32'd0);
        check("discard_x4", b_rd[63:32], 32'd0);
        do_cycle();

        // No-forwarding build shows the old value until the edge.
        drive(1, 0, 0, 5'd5, 32'h10, 0, 5'd0, 5'd5, 5'd0);
        do_cycle();
        drive(1, 0, 0, 5'd5, 32'h20, 0, 5'd0, 5'd5, 5'd0);
        #1;
        check("nob_old", n_rd[31:0], 32'h10);
        check("byp_new", b_rd[31:0], 32'h20);
        do_cycle();
        idle(5'd5, 5'd0);
        #1;
        check("nob_next", n_rd[31:0], 32'h20);
        do_cycle();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_dut(int'($urandom_range(0, 1)));
            end else begin
                logic [4:0] w;
                w = rnd_idx();
                drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), w, $urandom,
                      ($urandom_range(0, 1) == 0), rnd_idx(),
                      ($urandom_range(0, 2) == 0) ? w : rnd_idx(), rnd_idx());
                do_cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
